obf_key_loader: RTL and testbench



---
 rtl/obf_key_pkg.sv | 30 +++
 rtl/obf_key_shreg.sv | 37 +++
 rtl/obf_key_loader.sv | 109 ++++++++++
 tb/tb_obf_key_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/obf_key_pkg.sv
// obf_key_pkg: shared state encoding, default widths and the checksum fold.
`default_nettype none

package obf_key_pkg;

  localparam int KEY_WIDTH_DEF = 12;
  localparam int CHK_WIDTH_DEF = 4;
  localparam logic [KEY_WIDTH_DEF-1:0] DECOY_KEY_DEF = 12'h5A3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_DEAD   = 3'd4
  } state_t;

  // Zero padding above the real key width leaves the XOR unchanged, so any key up to 64 bits folds correctly.
  function automatic logic [CHK_WIDTH_DEF-1:0] xor_fold(input logic [63:0] key);
    logic [CHK_WIDTH_DEF-1:0] acc;
    acc = '0;
    for (int i = 0; i < 64 / CHK_WIDTH_DEF; i++) begin
      acc = acc ^ key[i*CHK_WIDTH_DEF +: CHK_WIDTH_DEF];
    end
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/obf_key_shreg.sv
// obf_key_shreg: FRAME-bit LSB-first shift register with accepted-bit counter.
`default_nettype none

module obf_key_shreg #(
  parameter int FRAME = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [FRAME-1:0] data,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(FRAME + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (shift_en) begin
      // Shift right so the first accepted bit ends up in data[0].
      data  <= {ser_in, data[FRAME-1:1]};
      count <= count + CNT_W'(1);
    end
  end

  assign frame_done = shift_en && !clear && (count == CNT_W'(FRAME - 1));

endmodule

`default_nettype wire

// File: rtl/obf_key_loader.sv
// obf_key_loader: serial write-once key loader with checksum and failure lockout;
// drives a decoy key to the camouflaged core until a valid key is committed.
`default_nettype none

module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter int                   KEY_WIDTH = KEY_WIDTH_DEF,
  parameter int                   CHK_WIDTH = CHK_WIDTH_DEF,
  parameter logic [KEY_WIDTH-1:0] DECOY_KEY = DECOY_KEY_DEF,
  parameter int                   MAX_FAIL  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 ser_in,
  input  logic                 ser_valid,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 err,
  output logic                 dead
);

  localparam int FRAME = KEY_WIDTH + CHK_WIDTH;

  state_t               state;
  logic [3:0]           fail_cnt;
  logic [3:0]           fail_next;
  logic [FRAME-1:0]     frame;
  logic                 frame_done;
  logic                 sr_clear;
  logic                 sr_shift;
  logic [KEY_WIDTH-1:0] rx_key;
  logic [CHK_WIDTH-1:0] rx_chk;
  logic                 chk_ok;

  assign sr_clear  = load_start && (state == ST_IDLE || state == ST_SHIFT);
  assign sr_shift  = (state == ST_SHIFT) && ser_valid && !load_start;
  assign rx_key    = frame[KEY_WIDTH-1:0];
  assign rx_chk    = frame[FRAME-1:KEY_WIDTH];
  assign chk_ok    = (xor_fold(64'(rx_key)) == rx_chk);
  assign fail_next = (fail_cnt < 4'(MAX_FAIL)) ? fail_cnt + 4'd1 : fail_cnt;

  obf_key_shreg #(.FRAME(FRAME)) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .clear      (sr_clear),
    .shift_en   (sr_shift),
    .ser_in     (ser_in),
    .data       (frame),
    .frame_done (frame_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      fail_cnt  <= '0;
      key_out   <= DECOY_KEY;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      dead      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state <= ST_SHIFT;
            busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!load_start && frame_done) state <= ST_CHECK;
        end
        ST_CHECK: begin
          busy <= 1'b0;
          if (chk_ok) begin
            state     <= ST_LOCKED;
            key_out   <= rx_key;
            key_valid <= 1'b1;
          end else begin
            err      <= 1'b1;
            fail_cnt <= fail_next;
            if (fail_next == 4'(MAX_FAIL)) begin
              state <= ST_DEAD;
              dead  <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_LOCKED: state <= ST_LOCKED;
        ST_DEAD:   state <= ST_DEAD;
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  a_widths: assert property (@(posedge clk)
    (KEY_WIDTH % CHK_WIDTH == 0) && (CHK_WIDTH == CHK_WIDTH_DEF) &&
    (MAX_FAIL >= 1) && (MAX_FAIL <= 15));

endmodule

`default_nettype wire

// File: tb/tb_obf_key_loader.sv
// tb_obf_key_loader: directed frames with a scoreboard of expected DUT events.
`default_nettype none

module tb_obf_key_loader;

  localparam int EV_OK   = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_DEAD = 2;

  typedef struct {
    int          kind;
    logic [11:0] key;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        ser_in = 1'b0;
  logic        ser_valid = 1'b0;
  logic [11:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;
  logic        dead;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic prev_kv = 1'b0;
  logic prev_dead = 1'b0;

  obf_key_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .busy       (busy),
    .err        (err),
    .dead       (dead)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic mon_event(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", 32'(kind), 32'hFFFF);
    end else begin
      e = q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_key", 32'(key_out), 32'(e.key));
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst) begin
      if (err) mon_event(EV_ERR);
      if (key_valid && !prev_kv) mon_event(EV_OK);
      if (dead && !prev_dead) mon_event(EV_DEAD);
    end
    prev_kv   = key_valid;
    prev_dead = dead;
  end

  task automatic push(input int kind, input logic [11:0] key);
    exp_t e;
    e.kind = kind;
    e.key  = key;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start();
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ser_in    = b;
    ser_valid = 1'b1;
    @(posedge clk);
    #1 ser_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] key, input logic [3:0] cs, input bit gaps);
    logic [15:0] f;
    f = {cs, key};
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
      if (gaps) #1;
      send_bit(f[i]);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 40 && q.size() != 0; n++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      chk(name, 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_key_out", 32'(key_out), 32'h5A3);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dead", 32'(dead), 32'd0);

    // Good load with exact latency
    push(EV_OK, 12'hA5C);
    start();
    chk("shift_busy", 32'(busy), 32'd1);
    send_frame(12'hA5C, 4'h3, 1'b0);
    chk("check_busy", 32'(busy), 32'd1);
    chk("check_kv_low", 32'(key_valid), 32'd0);
    chk("check_key_decoy", 32'(key_out), 32'h5A3);
    @(posedge clk); #1;
    chk("good_key_valid", 32'(key_valid), 32'd1);
    chk("good_key_out", 32'(key_out), 32'hA5C);
    chk("good_err", 32'(err), 32'd0);
    chk("good_busy", 32'(busy), 32'd0);
    wait_drain("good_drain");

    // Write-once: second good frame ignored
    start();
    chk("wo_busy_start", 32'(busy), 32'd0);
    send_frame(12'h123, 4'h0, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("wo_key_out", 32'(key_out), 32'hA5C);
    chk("wo_busy", 32'(busy), 32'd0);
    chk("wo_key_valid", 32'(key_valid), 32'd1);

    // Bad checksum
    do_reset();
    push(EV_ERR, 12'h5A3);
    start();
    send_frame(12'hA5C, 4'h2, 1'b0);
    @(posedge clk); #1;
    chk("bad_err_pulse", 32'(err), 32'd1);
    chk("bad_key_out", 32'(key_out), 32'h5A3);
    @(posedge clk); #1;
    chk("bad_err_clear", 32'(err), 32'd0);
    chk("bad_key_valid", 32'(key_valid), 32'd0);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_dead", 32'(dead), 32'd0);
    wait_drain("bad_drain");

    // Lockout after three failures
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push(EV_ERR, 12'h5A3);
      if (k == 2) push(EV_DEAD, 12'h5A3);
      start();
      send_frame(12'hA5C, 4'h2, 1'b0);
      repeat (2) @(posedge clk); #1;
      chk("lock_dead_flag", 32'(dead), (k == 2) ? 32'd1 : 32'd0);
    end
    wait_drain("lock_drain");
    start();
    send_frame(12'hA5C, 4'h3, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("dead_key_out", 32'(key_out), 32'h5A3);
    chk("dead_key_valid", 32'(key_valid), 32'd0);
    chk("dead_hold", 32'(dead), 32'd1);

    // Restart mid-frame, bit on restart cycle discarded, stalls in frame
    do_reset();
    start();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    load_start = 1'b1;
    ser_valid  = 1'b1;
    ser_in     = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
    ser_valid = 1'b0;
    push(EV_OK, 12'hA5C);
    send_frame(12'hA5C, 4'h3, 1'b1);
    @(posedge clk); #1;
    chk("restart_key_out", 32'(key_out), 32'hA5C);
    chk("restart_key_valid", 32'(key_valid), 32'd1);
    wait_drain("restart_drain");

    // Asynchronous reset mid-SHIFT, then a clean load
    do_reset();
    start();
    for (int i = 0; i < 9; i++) send_bit(1'b0);
    chk("ar_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_key_out", 32'(key_out), 32'h5A3);
    chk("ar_key_valid", 32'(key_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    push(EV_OK, 12'hA5C);
    start();
    send_frame(12'hA5C, 4'h3, 1'b0);
    @(posedge clk); #1;
    chk("ar_reload_key", 32'(key_out), 32'hA5C);
    wait_drain("ar_drain");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
